// File: rtl/btn_debounce_multi_if.sv
// rtl/btn_debounce_multi_if.sv - tick/button inputs and debounced event outputs of btn_debounce_multi
interface btn_debounce_multi_if #(
    parameter int N_CH = 4
);
    logic            tick;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic [N_CH-1:0] btn_hold;

    modport master (
        output tick, btn_in,
        input  btn_level, btn_rise, btn_fall, btn_hold
    );

    modport slave (
        input  tick, btn_in,
        output btn_level, btn_rise, btn_fall, btn_hold
    );
endinterface

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - multi-channel synchronising button debouncer with long-press/auto-repeat
module btn_debounce_multi #(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = 16,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_debounce_multi_if.slave  bus
);
    localparam int CW    = $clog2(STABLE_TICKS + 1);
    localparam int HMAX0 = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HMAX  = (HMAX0 > 1) ? HMAX0 : 1;
    localparam int HW    = $clog2(HMAX + 1);

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
    localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

    typedef enum logic [1:0] {H_IDLE, H_FIRST, H_REPEAT, H_DONE} hold_state_e;

    logic [SYNC_STAGES-1:0] sync_q   [N_CH];
    logic [CW-1:0]          cnt_q    [N_CH];
    logic [HW-1:0]          hcnt_q   [N_CH];
    hold_state_e            hstate_q [N_CH];

    logic [N_CH-1:0] s_d;
    logic [N_CH-1:0] level_q;
    logic [N_CH-1:0] rise_d, rise_q;
    logic [N_CH-1:0] fall_d, fall_q;
    logic [N_CH-1:0] hold_d, hold_q;

    // A release completing on the hold terminal tick suppresses that hold pulse.
    always_comb begin
        s_d    = '0;
        rise_d = '0;
        fall_d = '0;
        hold_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            s_d[c] = sync_q[c][SYNC_STAGES-1];
            if (bus.tick && (sync_q[c][SYNC_STAGES-1] != level_q[c]) && (cnt_q[c] == STABLE_LAST)) begin
                rise_d[c] = sync_q[c][SYNC_STAGES-1];
                fall_d[c] = ~sync_q[c][SYNC_STAGES-1];
            end
            if (bus.tick && !fall_d[c]) begin
                if ((hstate_q[c] == H_FIRST) && (hcnt_q[c] == HOLD_LAST)) begin
                    hold_d[c] = 1'b1;
                end
                if ((hstate_q[c] == H_REPEAT) && (hcnt_q[c] == REPEAT_LAST)) begin
                    hold_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            hold_q  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                sync_q[c]   <= '0;
                cnt_q[c]    <= '0;
                hcnt_q[c]   <= '0;
                hstate_q[c] <= H_IDLE;
            end
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            hold_q <= hold_d;
            for (int c = 0; c < N_CH; c++) begin
                sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], bus.btn_in[c] ^ ACTIVE_LOW};

                if (s_d[c] == level_q[c]) begin
                    cnt_q[c] <= '0;
                end else if (bus.tick) begin
                    if (cnt_q[c] == STABLE_LAST) begin
                        level_q[c] <= s_d[c];
                        cnt_q[c]   <= '0;
                    end else begin
                        cnt_q[c] <= cnt_q[c] + 1'b1;
                    end
                end

                if (fall_d[c]) begin
                    hstate_q[c] <= H_IDLE;
                    hcnt_q[c]   <= '0;
                end else begin
                    unique case (hstate_q[c])
                        H_IDLE: begin
                            if (rise_d[c]) begin
                                hcnt_q[c]   <= '0;
                                hstate_q[c] <= (HOLD_TICKS == 0) ? H_DONE : H_FIRST;
                            end
                        end
                        H_FIRST: begin
                            if (bus.tick) begin
                                if (hcnt_q[c] == HOLD_LAST) begin
                                    hcnt_q[c]   <= '0;
                                    hstate_q[c] <= (REPEAT_TICKS > 0) ? H_REPEAT : H_DONE;
                                end else begin
                                    hcnt_q[c] <= hcnt_q[c] + 1'b1;
                                end
                            end
                        end
                        H_REPEAT: begin
                            if (bus.tick) begin
                                if (hcnt_q[c] == REPEAT_LAST) begin
                                    hcnt_q[c] <= '0;
                                end else begin
                                    hcnt_q[c] <= hcnt_q[c] + 1'b1;
                                end
                            end
                        end
                        default: begin
                            hcnt_q[c] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.btn_level = level_q;
    assign bus.btn_rise  = rise_q;
    assign bus.btn_fall  = fall_q;
    assign bus.btn_hold  = hold_q;
endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - checks active-high and active-low debouncer instances against a behavioural model
module tb_btn_debounce_multi;
    localparam int N  = 4;
    localparam int SS = 2;
    localparam int ST = 4;
    localparam int HT = 10;
    localparam int RT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btn_debounce_multi_if #(.N_CH(N)) bus_h ();
    btn_debounce_multi_if #(.N_CH(N)) bus_l ();

    btn_debounce_multi #(.N_CH(N), .SYNC_STAGES(SS), .STABLE_TICKS(ST), .HOLD_TICKS(HT),
                         .REPEAT_TICKS(RT), .ACTIVE_LOW(1'b0))
        dut_h (.clk(clk), .rst(rst), .bus(bus_h));

    btn_debounce_multi #(.N_CH(N), .SYNC_STAGES(SS), .STABLE_TICKS(ST), .HOLD_TICKS(HT),
                         .REPEAT_TICKS(RT), .ACTIVE_LOW(1'b1))
        dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    int n_checks = 0;
    int n_errors = 0;

    // Model: pressed-state history, ticks of disagreement, ticks since press.
    logic [N-1:0] m_hist [SS];
    logic [N-1:0] m_lvl, m_rise, m_fall, m_hold;
    int           m_run  [N];
    int           m_since[N];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic tk, input logic [N-1:0] pressed);
        logic [N-1:0] s;
        s = m_hist[SS-1];
        for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = pressed;
        m_rise = '0;
        m_fall = '0;
        m_hold = '0;
        if (r) begin
            for (int i = 0; i < SS; i++) m_hist[i] = '0;
            m_lvl = '0;
            for (int c = 0; c < N; c++) begin
                m_run[c]   = 0;
                m_since[c] = -1;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (s[c] == m_lvl[c]) m_run[c] = 0;
                else if (tk) begin
                    m_run[c]++;
                    if (m_run[c] == ST) begin
                        m_lvl[c] = s[c];
                        m_run[c] = 0;
                        if (s[c]) m_rise[c] = 1'b1;
                        else      m_fall[c] = 1'b1;
                    end
                end
                if (m_fall[c]) m_since[c] = -1;
                else if (m_rise[c]) m_since[c] = 0;
                else if (m_since[c] >= 0 && tk) begin
                    m_since[c]++;
                    if (m_since[c] == HT) m_hold[c] = 1'b1;
                    else if (m_since[c] > HT && ((m_since[c] - HT) % RT) == 0) m_hold[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic tk, input logic [N-1:0] b);
        rst          = r;
        bus_h.tick   = tk;
        bus_l.tick   = tk;
        bus_h.btn_in = b;
        bus_l.btn_in = ~b;
        @(posedge clk);
        model_step(r, tk, b);
        #1;
        check("level_h", bus_h.btn_level, m_lvl);
        check("rise_h",  bus_h.btn_rise,  m_rise);
        check("fall_h",  bus_h.btn_fall,  m_fall);
        check("hold_h",  bus_h.btn_hold,  m_hold);
        check("level_l", bus_l.btn_level, m_lvl);
        check("rise_l",  bus_l.btn_rise,  m_rise);
        check("fall_l",  bus_l.btn_fall,  m_fall);
        check("hold_l",  bus_l.btn_hold,  m_hold);
    endtask

    initial begin
        int holds[$];
        int rt, fall_rt, cyc, after_fall, div;
        logic rel, tk;
        logic [N-1:0] b;

        // reset with all inputs pressed
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hF);
        check("lit_rst_level", bus_h.btn_level, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        check("lit_post_rst_level", bus_h.btn_level | bus_h.btn_rise | bus_h.btn_hold, 4'h0);
        check("lit_post_rst_level_l", bus_l.btn_level, 4'h0);
        step(1'b0, 1'b1, 4'h0);

        // clean press on ch0: visible after edge SS+ST = 6
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 4'b0001);
            check("lit_press_level", bus_h.btn_level, (k >= 6) ? 4'b0001 : 4'b0000);
            check("lit_press_rise",  bus_h.btn_rise,  (k == 6) ? 4'b0001 : 4'b0000);
            check("lit_press_rise_l", bus_l.btn_rise, (k == 6) ? 4'b0001 : 4'b0000);
            if (k == 6) check("lit_model_rise", m_rise, 4'b0001);
        end

        // bounce on ch1: 3 high, 2 low, then steady high; single rise after edge 11
        for (int j = 1; j <= 16; j++) begin
            b = ((j <= 3) || (j >= 6)) ? 4'b0011 : 4'b0001;
            step(1'b0, 1'b1, b);
            check("lit_bounce_rise", bus_h.btn_rise & 4'b0010, (j == 11) ? 4'b0010 : 4'b0000);
            check("lit_bounce_fall", bus_h.btn_fall & 4'b0010, 4'b0000);
        end

        // hold/repeat on ch2, tick every 4 clocks; release timed so fall lands on a repeat terminal tick
        rt = -1; fall_rt = -1; rel = 1'b0; after_fall = 0;
        for (int i = 0; i < 200 && after_fall < 40; i++) begin
            tk = (i % 4) == 0;
            step(1'b0, tk, rel ? 4'b0011 : 4'b0111);
            if (bus_h.btn_rise[2]) rt = 0;
            else if (rt >= 0 && tk) rt++;
            if (bus_h.btn_hold[2]) holds.push_back(rt);
            if (bus_h.btn_fall[2]) fall_rt = rt;
            if (rt == 18) rel = 1'b1;
            if (fall_rt >= 0) after_fall++;
        end
        n_checks++;
        if (holds.size() != 4) begin
            n_errors++;
            $display("FAIL hold_count: actual=%0d expected=4", holds.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (holds[i] != 10 + 3 * i) begin
                    n_errors++;
                    $display("FAIL hold_tick[%0d]: actual=%0d expected=%0d", i, holds[i], 10 + 3 * i);
                end
            end
        end
        n_checks++;
        if (fall_rt != 22) begin
            n_errors++;
            $display("FAIL hold_fall_tick: actual=%0d expected=22", fall_rt);
        end

        // release all, then reset at the 2nd mismatch tick of a ch0 press
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 4'h0);
        for (int k = 1; k <= 3; k++) step(1'b0, 1'b1, 4'b0001);
        step(1'b1, 1'b1, 4'b0001);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 4'b0001);
            check("lit_rstmid_rise",  bus_h.btn_rise,  (k == 6) ? 4'b0001 : 4'b0000);
            check("lit_rstmid_level", bus_h.btn_level, (k >= 6) ? 4'b0001 : 4'b0000);
        end

        // randomized traffic with varying bounce rate and occasional reset
        b = 4'h0; div = 10;
        for (cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 400 == 0) div = $urandom_range(3, 60);
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, div - 1) == 0) b[c] = ~b[c];
            step($urandom_range(0, 799) == 0, $urandom_range(0, 2) != 0, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
Parametrised, multi-channel successor to the single-button edge debouncer. Each channel is synchronised, then debounced with a tick-driven stability counter. Each channel produces a clean level, one-clock rise and fall pulses, and a long-press / auto-repeat pulse. The block sits between the raw Arty Z7 button/switch pins and the lock FSM, and replaces per-button instances.

Parameters:
N_CH, 4, number of independent input channels
SYNC_STAGES, 2, synchroniser flops per channel (legal range 2..4)
STABLE_TICKS, 16, consecutive mismatching ticks required before the debounced level changes (>=1)
HOLD_TICKS, 500, ticks of continuous high level before the first btn_hold pulse (0 disables hold and repeat)
REPEAT_TICKS, 100, ticks between subsequent btn_hold pulses while still held (0 gives a single hold pulse only)
ACTIVE_LOW, 0, 1 inverts btn_in before the synchroniser, so a pressed channel always reads 1 internally

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
tick  input  1  sample-enable strobe, one clk wide (for example 1 kHz); counters advance only on tick
btn_in  input  N_CH  raw asynchronous button inputs
btn_level  output  N_CH  debounced level, 1 = pressed
btn_rise  output  N_CH  one-clk pulse on debounced press
btn_fall  output  N_CH  one-clk pulse on debounced release
btn_hold  output  N_CH  one-clk pulse on long-press and on each auto-repeat

Behaviour:
- One clock and one synchronous active-high reset (rst) for the whole block. All logic is on the rising edge of clk.
- Reset: clear all synchroniser flops, btn_level, btn_rise, btn_fall, btn_hold, the stability counter and the hold counter to 0. Hold state goes to H_IDLE.
- Reset has priority over everything. An rst assertion during a pending transition discards the transition.
- Channels are fully independent. There is no cross-channel interaction.
- Synchroniser: a SYNC_STAGES-deep shift on every clk, not gated by tick. Its input is btn_in XOR ACTIVE_LOW. Call its last stage s.
- Stability counter, width clog2(STABLE_TICKS+1):
  - On any clk with s == btn_level: cnt <= 0.
  - On a clk with tick=1 and s != btn_level: if cnt == STABLE_TICKS-1, then btn_level <= s and cnt <= 0, and assert btn_rise (s=1) or btn_fall (s=0) in the same cycle btn_level first shows the new value. Otherwise cnt <= cnt+1.
  - tick=0 with a mismatch: cnt holds.
- Latency with tick held at 1: a raw step is visible on btn_level exactly SYNC_STAGES+STABLE_TICKS clk edges after the first edge that samples it.
- A glitch shorter than STABLE_TICKS ticks produces no output change and no pulse.
- btn_rise, btn_fall and btn_hold are high for exactly one clk, then drop to 0 unless re-triggered.
- Hold FSM per channel, states H_IDLE, H_FIRST, H_REPEAT, H_DONE. Hold counter width is clog2(max(HOLD_TICKS, REPEAT_TICKS, 1)+1).
  - H_IDLE: on btn_rise, hcnt <= 0 and go to H_FIRST. If HOLD_TICKS=0, go to H_DONE instead.
  - H_FIRST, on tick: if hcnt == HOLD_TICKS-1, pulse btn_hold, set hcnt <= 0, and go to H_REPEAT (REPEAT_TICKS>0) or H_DONE (REPEAT_TICKS=0). Otherwise hcnt++.
  - H_REPEAT, on tick: if hcnt == REPEAT_TICKS-1, pulse btn_hold and set hcnt <= 0. Otherwise hcnt++.
  - H_DONE: wait, counter idle.
  - Any state: btn_fall returns the FSM to H_IDLE and clears hcnt.
- The hold counter counts ticks while btn_level=1. Counting starts on the first tick after the btn_rise cycle.
- Simultaneous events: if the tick that completes a release debounce is also the hold terminal tick, btn_fall wins and btn_hold is not pulsed.
- btn_rise and btn_hold are never asserted in the same cycle.
- Outputs are registered. There is no combinational path from btn_in or tick to any output.

Test Plan:
1. Reset: N_CH=4, STABLE_TICKS=4, tick=1. Assert rst for 3 clks with btn_in=4'hF -> all outputs 0 during reset and on the first cycle after release.
2. Clean press on ch0, tick every clk, SYNC_STAGES=2, STABLE_TICKS=4. btn_in[0] 0->1 sampled at edge 1 -> btn_level[0]=1 and btn_rise[0]=1 after edge 6; btn_rise[0]=0 after edge 7. Other channels stay 0.
3. Bounce: btn_in[1] pulses high for 3 ticks, low for 2, then high steady -> exactly one btn_rise[1], 4 ticks after the steady edge reaches s. No btn_fall[1].
4. Hold/repeat: HOLD_TICKS=10, REPEAT_TICKS=3, tick every 4 clks, ch2 held for 20 ticks -> btn_hold[2] pulses at ticks 10, 13, 16 and 19 after rise; release gives btn_fall[2] and no further hold pulses.
5. ACTIVE_LOW=1: btn_in=4'hF idle -> btn_level=0. ch3 driven 0 -> btn_rise[3] after the debounce interval.
6. Reset mid-debounce: assert rst at the 2nd of 4 mismatch ticks on ch0 -> no btn_rise. After release, the input must be stable again for the full STABLE_TICKS interval before btn_rise[0] asserts.
